ppu_bus_bridge: RTL and testbench
=================================

Name: ppu_bus_bridge

Overview:
- CPU-side bridge to the PPU register file ($2000-$3FFF, mirrored every 8 bytes), the OAM DMA port ($4014) and the serial joypad ports ($4016+).
- Second generation of the CPU/PPU memory decoder:
  - real shared write-toggle latch for $2005/$2006
  - buffered $2007 reads with palette bypass
  - cycle-stealing OAM DMA engine
  - parametrised pad count and widths
- Sits between the CPU bus arbiter and the PPU/VRAM/OAM memories. Main RAM/PRG decode stays outside this block.

Parameters:
- VADDR_W, 14, VRAM address width; vram_addr wraps modulo 2^VADDR_W.
- OAM_DEPTH, 256, OAM bytes; also the DMA transfer length. Power of 2, at most 256.
- NUM_PADS, 2, joypad channels at $4016..$4016+NUM_PADS-1. Range 1..2.
- PAD_BITS, 8, buttons per pad, shifted out LSB first.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data; combinational from address and registers
- cpu_we / cpu_re  in  1  one-cycle access strobes
- cpu_hit  out  1  address belongs to this block
- cpu_stall  out  1  CPU must hold (DMA active)
- ppu_ctrl / ppu_mask  out  8  $2000 / $2001 registers
- ppu_status_in  in  3  vblank, sprite0, overflow flags (bits 7:5)
- status_rd  out  1  one-cycle pulse on a $2002 read
- scroll_x / scroll_y  out  8  $2005 first / second write
- vram_addr  out  VADDR_W  current VRAM pointer
- vram_wdata  out  8  VRAM write data
- vram_we / vram_re  out  1  VRAM strobes; read data arrives 1 cycle later
- vram_rdata  in  8  VRAM read data
- pal_rdata  in  8  palette data for vram_addr, combinational
- oam_addr  out  8  OAM address (register or DMA-driven)
- oam_wdata  out  8  OAM write data
- oam_we  out  1  OAM write strobe
- oam_rdata  in  8  OAM read data, combinational
- dma_addr  out  16  DMA source address on the CPU bus
- dma_re  out  1  DMA source read strobe; data arrives 1 cycle later
- dma_rdata  in  8  DMA source data
- pad_state  in  NUM_PADS*PAD_BITS  parallel button levels, pad i at bits [i*PAD_BITS +: PAD_BITS]

Behaviour:
- Reset: every register, output and the pad shift registers are 0; w = 0; DMA state IDLE. An asynchronous reset mid-DMA aborts it and cpu_stall drops immediately.
- Decode:
  - $2000-$3FFF: register r = addr[2:0]
  - $4014: DMA trigger
  - $4016+i: pads
  - cpu_hit = 1 for any of these. Other addresses: cpu_rdata = 0, no side effects.
- Strobe gating: cpu_we and cpu_re are ignored while cpu_stall = 1.
- Open bus latch: every accepted write to a hit address stores cpu_wdata.
- Register writes take effect at the next edge:
  - r0 -> ppu_ctrl
  - r1 -> ppu_mask
  - r3 -> oam_addr register
  - r4 -> OAM write at oam_addr, then oam_addr+1 (8-bit wrap)
- $2005 write: w=0 writes scroll_x, w=1 writes scroll_y; w toggles.
- $2006 write:
  - w=0 stores hi = data & 0x3F.
  - w=1 sets vram_addr = {hi, data} truncated to VADDR_W.
  - w toggles.
- $2002 read:
  - cpu_rdata = {ppu_status_in, openbus[4:0]}
  - status_rd pulses for 1 cycle
  - w cleared
- Other register reads: $2004 returns oam_rdata; write-only registers return openbus.
- $2007 write: vram_we = 1 and vram_wdata = data for that cycle.
- $2007 read:
  - cpu_rdata = pal_rdata if vram_addr >= 0x3F00, else rbuf.
  - vram_re = 1 at the current vram_addr; rbuf <= vram_rdata one cycle later.
- $2007 address increment: after any $2007 access, vram_addr += (ppu_ctrl[2] ? 32 : 1), wrapping modulo 2^VADDR_W.
- DMA: a write of P to $4014 runs state machine IDLE -> ALIGN (1 cycle) -> {RD, WR} x OAM_DEPTH -> IDLE.
  - RD i: dma_re = 1, dma_addr = {P, i}.
  - WR i: oam_we = 1, oam_addr = base+i (8-bit wrap), oam_wdata = dma_rdata.
  - base is the oam_addr register at trigger; the register is unchanged afterwards.
  - cpu_stall is high from the cycle after the trigger write through the last WR: 1 + 2*OAM_DEPTH cycles (513 by default).
- Pads:
  - Write $4016: strobe = data[0], common to all pads.
  - While strobe = 1, each shift register reloads from pad_state every cycle, and a read returns bit 0.
  - Read $4016+i with strobe = 0: cpu_rdata = {openbus[7:1], sr_i[0]}; then sr_i shifts right, filling with 1.
  - After PAD_BITS reads, the pad returns 1 on every further read.
- Simultaneous events:
  - A $2002 read and the w toggle cannot coincide (single bus).
  - A $2007 read with rbuf refill pending: the new address is issued and the later refill wins.

Decomposition:
- Package ppu_bus_pkg:
  - register offsets R_CTRL..R_DATA
  - ADDR_OAMDMA 16'h4014, ADDR_PAD0 16'h4016
  - PALETTE_BASE 14'h3F00
  - DMA state enum {IDLE, ALIGN, RD, WR}
- One sub-module, oam_dma_engine: trigger, page and base in; dma_* and oam_* write strobes and stall out.
- Pad shifters stay as a generate loop in the top level.

Test Plan:
- Write $2006=0x21, $2006=0x08, $2007=0xAB -> vram_we with vram_addr=0x2108, data 0xAB; vram_addr becomes 0x2109. Set ppu_ctrl=0x04, write again -> next address 0x2129.
- Write $2006=0x3F once, read $2002, then write $2006=0x20, $2006=0x00 -> vram_addr=0x2000, confirming w was cleared by the status read.
- vram_addr=0x2000, VRAM holds 0x11,0x22: first $2007 read returns old rbuf (0), second returns 0x11. At 0x3F00, a read returns pal_rdata directly.
- oam_addr=0x10, write $4014=0x02 -> cpu_stall for exactly 513 cycles; dma_addr sweeps 0x0200..0x02FF; OAM writes land at 0x10..0xFF, then 0x00..0x0F; oam_addr ends at 0x10.
- Assert rst at DMA cycle 100 -> cpu_stall=0, no further oam_we; a new trigger restarts cleanly.
- pad_state pad0=0xA5: write $4016=1, then 0; 10 reads of $4016 -> bit0 sequence 1,0,1,0,0,1,0,1,1,1.

Source files
------------

// File: rtl/ppu_bus_pkg.sv
// Shared constants and types for the CPU-side PPU bus bridge.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package ppu_bus_pkg;

  // PPU register offsets within each 8-byte mirror of $2000-$3FFF
  localparam logic [2:0] R_CTRL    = 3'd0;
  localparam logic [2:0] R_MASK    = 3'd1;
  localparam logic [2:0] R_STATUS  = 3'd2;
  localparam logic [2:0] R_OAMADDR = 3'd3;
  localparam logic [2:0] R_OAMDATA = 3'd4;
  localparam logic [2:0] R_SCROLL  = 3'd5;
  localparam logic [2:0] R_ADDR    = 3'd6;
  localparam logic [2:0] R_DATA    = 3'd7;

  localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
  localparam logic [15:0] ADDR_PAD0    = 16'h4016;
  localparam logic [13:0] PALETTE_BASE = 14'h3F00;

  typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} dma_state_t;

  // Address classification for one CPU bus cycle
  typedef struct packed {
    logic ppu_reg;
    logic dma;
    logic pad;
  } bus_dec_t;

  function automatic logic is_ppu_reg(input logic [15:0] addr);
    return addr[15:13] == 3'b001;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// Cycle-stealing OAM DMA: copies one 256-byte-max CPU page into OAM starting at base.
// Latency: stall rises the cycle after trig, lasts 1 + 2*OAM_DEPTH cycles.
// Backpressure: none accepted; owns the bus and holds the CPU via stall until done.
// Ports: trig/page/base in; dma_addr/dma_re out, dma_rdata in (1-cycle latency);
//        oam_addr/oam_wdata/oam_we out; stall out.
module oam_dma_engine
  import ppu_bus_pkg::*;
#(
  parameter int OAM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [7:0]  page,
  input  logic [7:0]  base,
  input  logic [7:0]  dma_rdata,
  output logic [15:0] dma_addr,
  output logic        dma_re,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        stall
);

  localparam logic [7:0] LAST = 8'(OAM_DEPTH - 1);

  dma_state_t state;
  logic [7:0] page_q;
  logic [7:0] base_q;
  logic [7:0] idx;

  // Source data returns the cycle after RD, i.e. exactly during WR
  assign oam_wdata = oam_we ? dma_rdata : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      page_q   <= '0;
      base_q   <= '0;
      idx      <= '0;
      dma_addr <= '0;
      dma_re   <= 1'b0;
      oam_addr <= '0;
      oam_we   <= 1'b0;
      stall    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state  <= ALIGN;
            stall  <= 1'b1;
            page_q <= page;
            base_q <= base;
            idx    <= '0;
          end
        end
        ALIGN: begin
          state    <= RD;
          dma_re   <= 1'b1;
          dma_addr <= {page_q, 8'h00};
        end
        RD: begin
          state    <= WR;
          dma_re   <= 1'b0;
          oam_we   <= 1'b1;
          oam_addr <= base_q + idx;
        end
        WR: begin
          oam_we <= 1'b0;
          if (idx == LAST) begin
            state <= IDLE;
            stall <= 1'b0;
          end else begin
            idx      <= idx + 8'd1;
            state    <= RD;
            dma_re   <= 1'b1;
            dma_addr <= {page_q, idx + 8'd1};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ppu_bus_bridge.sv
// CPU-side bridge to PPU registers ($2000-$3FFF mirrored), OAM DMA ($4014) and joypads ($4016+).
// Latency: reads combinational; register writes land at the next edge; $2007 reads via 1-deep buffer.
// Backpressure: cpu_stall holds the CPU during OAM DMA; strobes are ignored while stalled.
// Ports: cpu_* bus side; ppu_ctrl/mask/scroll/status PPU side; vram_*/pal_rdata VRAM side;
//        oam_* OAM side; dma_* DMA source side; pad_state parallel button levels.
module ppu_bus_bridge
  import ppu_bus_pkg::*;
#(
  parameter int VADDR_W   = 14,
  parameter int OAM_DEPTH = 256,
  parameter int NUM_PADS  = 2,
  parameter int PAD_BITS  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [15:0]                  cpu_addr,
  input  logic [7:0]                   cpu_wdata,
  output logic [7:0]                   cpu_rdata,
  input  logic                         cpu_we,
  input  logic                         cpu_re,
  output logic                         cpu_hit,
  output logic                         cpu_stall,
  output logic [7:0]                   ppu_ctrl,
  output logic [7:0]                   ppu_mask,
  input  logic [2:0]                   ppu_status_in,
  output logic                         status_rd,
  output logic [7:0]                   scroll_x,
  output logic [7:0]                   scroll_y,
  output logic [VADDR_W-1:0]           vram_addr,
  output logic [7:0]                   vram_wdata,
  output logic                         vram_we,
  output logic                         vram_re,
  input  logic [7:0]                   vram_rdata,
  input  logic [7:0]                   pal_rdata,
  output logic [7:0]                   oam_addr,
  output logic [7:0]                   oam_wdata,
  output logic                         oam_we,
  input  logic [7:0]                   oam_rdata,
  output logic [15:0]                  dma_addr,
  output logic                         dma_re,
  input  logic [7:0]                   dma_rdata,
  input  logic [NUM_PADS*PAD_BITS-1:0] pad_state
);

  bus_dec_t           dec;
  logic [15:0]        pad_off;
  logic [2:0]         r;
  logic               acc_we, acc_re, reg_wr, reg_rd;
  logic               cpu_oam_we, dma_trig;
  logic [7:0]         openbus, oam_addr_q, rbuf;
  logic               rbuf_pend, w, strobe, pal_sel;
  logic [5:0]         hi;
  logic [VADDR_W-1:0] vram_inc, addr_join;
  logic [NUM_PADS-1:0] pad_rd, pad_bit;
  logic               dma_oam_we;
  logic [7:0]         dma_oam_addr, dma_oam_wdata;

  // Address decode
  assign pad_off     = cpu_addr - ADDR_PAD0;  // wraps high below $4016, so one compare suffices
  assign dec.ppu_reg = is_ppu_reg(cpu_addr);
  assign dec.dma     = (cpu_addr == ADDR_OAMDMA);
  assign dec.pad     = (pad_off < 16'(NUM_PADS));
  assign cpu_hit     = dec.ppu_reg | dec.dma | dec.pad;
  assign r           = cpu_addr[2:0];

  // The CPU is frozen during DMA, so its strobes must not leak through
  assign acc_we   = cpu_we & ~cpu_stall;
  assign acc_re   = cpu_re & ~cpu_stall;
  assign reg_wr   = acc_we & dec.ppu_reg;
  assign reg_rd   = acc_re & dec.ppu_reg;
  assign dma_trig = acc_we & dec.dma;

  assign status_rd  = reg_rd & (r == R_STATUS);
  assign vram_we    = reg_wr & (r == R_DATA);
  assign vram_re    = reg_rd & (r == R_DATA);
  assign vram_wdata = vram_we ? cpu_wdata : 8'h00;
  assign cpu_oam_we = reg_wr & (r == R_OAMDATA);

  assign vram_inc  = ppu_ctrl[2] ? VADDR_W'(32) : VADDR_W'(1);
  assign addr_join = VADDR_W'({hi, cpu_wdata});
  assign pal_sel   = (vram_addr >= VADDR_W'(PALETTE_BASE));

  // DMA owns the OAM port only while it is actually writing
  assign oam_we    = dma_oam_we | cpu_oam_we;
  assign oam_addr  = dma_oam_we ? dma_oam_addr : oam_addr_q;
  assign oam_wdata = dma_oam_we ? dma_oam_wdata : (cpu_oam_we ? cpu_wdata : 8'h00);

  oam_dma_engine #(.OAM_DEPTH(OAM_DEPTH)) u_dma (
    .clk       (clk),
    .rst       (rst),
    .trig      (dma_trig),
    .page      (cpu_wdata),
    .base      (oam_addr_q),
    .dma_rdata (dma_rdata),
    .dma_addr  (dma_addr),
    .dma_re    (dma_re),
    .oam_addr  (dma_oam_addr),
    .oam_wdata (dma_oam_wdata),
    .oam_we    (dma_oam_we),
    .stall     (cpu_stall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      openbus    <= '0;
      ppu_ctrl   <= '0;
      ppu_mask   <= '0;
      oam_addr_q <= '0;
      scroll_x   <= '0;
      scroll_y   <= '0;
      hi         <= '0;
      w          <= 1'b0;
      vram_addr  <= '0;
      rbuf       <= '0;
      rbuf_pend  <= 1'b0;
      strobe     <= 1'b0;
    end else begin
      if (acc_we && cpu_hit) openbus <= cpu_wdata;
      if (reg_wr && r == R_CTRL) ppu_ctrl <= cpu_wdata;
      if (reg_wr && r == R_MASK) ppu_mask <= cpu_wdata;

      if (reg_wr && r == R_OAMADDR) oam_addr_q <= cpu_wdata;
      else if (cpu_oam_we)          oam_addr_q <= oam_addr_q + 8'd1;

      // Shared first/second-write toggle for $2005/$2006
      if (status_rd) w <= 1'b0;
      else if (reg_wr && (r == R_SCROLL || r == R_ADDR)) w <= ~w;

      if (reg_wr && r == R_SCROLL) begin
        if (!w) scroll_x <= cpu_wdata;
        else    scroll_y <= cpu_wdata;
      end

      if (reg_wr && r == R_ADDR) begin
        if (!w) hi <= cpu_wdata[5:0];
        else    vram_addr <= addr_join;
      end else if (vram_we || vram_re) begin
        vram_addr <= vram_addr + vram_inc;
      end

      // VRAM answers one cycle after vram_re; a newer request simply overwrites later
      rbuf_pend <= vram_re;
      if (rbuf_pend) rbuf <= vram_rdata;

      if (acc_we && cpu_addr == ADDR_PAD0) strobe <= cpu_wdata[0];
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
    logic [PAD_BITS-1:0] sr;
    assign pad_rd[gi]  = acc_re & (pad_off == 16'(gi));
    assign pad_bit[gi] = strobe ? pad_state[gi*PAD_BITS] : sr[0];
    // Shifts in 1s so an exhausted pad reads as all buttons pressed
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)            sr <= '0;
      else if (strobe)     sr <= pad_state[gi*PAD_BITS +: PAD_BITS];
      else if (pad_rd[gi]) sr <= {1'b1, sr[PAD_BITS-1:1]};
    end
  end

  always_comb begin
    cpu_rdata = 8'h00;
    if (dec.ppu_reg) begin
      case (r)
        R_STATUS:  cpu_rdata = {ppu_status_in, openbus[4:0]};
        R_OAMDATA: cpu_rdata = oam_rdata;
        R_DATA:    cpu_rdata = pal_sel ? pal_rdata : rbuf;
        default:   cpu_rdata = openbus;
      endcase
    end else if (dec.dma) begin
      cpu_rdata = openbus;
    end else if (dec.pad) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        if (pad_off == 16'(i)) cpu_rdata = {openbus[7:1], pad_bit[i]};
      end
    end
  end

endmodule

// File: tb/tb_ppu_bus_bridge.sv
// Scoreboard bench for ppu_bus_bridge: stimulus pushes expectations, a monitor checks outputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_ppu_bus_bridge;

  localparam int VADDR_W = 14, OAM_DEPTH = 256, NUM_PADS = 2, PAD_BITS = 8;

  logic clk, rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_re, cpu_hit, cpu_stall;
  logic [7:0]  ppu_ctrl, ppu_mask, scroll_x, scroll_y;
  logic [2:0]  ppu_status_in;
  logic        status_rd;
  logic [VADDR_W-1:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata, pal_rdata;
  logic        vram_we, vram_re;
  logic [7:0]  oam_addr, oam_wdata, oam_rdata;
  logic        oam_we;
  logic [15:0] dma_addr;
  logic        dma_re;
  logic [7:0]  dma_rdata;
  logic [NUM_PADS*PAD_BITS-1:0] pad_state;

  ppu_bus_bridge #(.VADDR_W(VADDR_W), .OAM_DEPTH(OAM_DEPTH), .NUM_PADS(NUM_PADS),
                   .PAD_BITS(PAD_BITS)) dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_hit(cpu_hit), .cpu_stall(cpu_stall),
    .ppu_ctrl(ppu_ctrl), .ppu_mask(ppu_mask), .ppu_status_in(ppu_status_in),
    .status_rd(status_rd), .scroll_x(scroll_x), .scroll_y(scroll_y), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re), .vram_rdata(vram_rdata),
    .pal_rdata(pal_rdata), .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .oam_rdata(oam_rdata), .dma_addr(dma_addr), .dma_re(dma_re), .dma_rdata(dma_rdata),
    .pad_state(pad_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models around the bridge
  logic [7:0] vram_mem [0:16383];
  logic [7:0] oam_mem  [0:255];
  always @(posedge clk) begin
    if (vram_re) vram_rdata <= vram_mem[vram_addr];
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    if (oam_we)  oam_mem[oam_addr] <= oam_wdata;
    if (dma_re)  dma_rdata <= dma_addr[7:0] ^ 8'h5A;
  end
  assign pal_rdata = 8'hC0 | {3'b000, vram_addr[4:0]};
  assign oam_rdata = oam_mem[oam_addr];

  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  typedef struct packed { logic [7:0] d; logic s; } rd_t;
  wr_t         exp_vram [$];
  wr_t         exp_oam  [$];
  logic [15:0] exp_dma  [$];
  rd_t         exp_rd   [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output seen with no expectation queued", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transaction
  initial begin
    wr_t e;
    rd_t rr;
    logic [15:0] da;
    forever begin
      @(negedge clk);
      if (vram_we) begin
        if (exp_vram.size() == 0) unexpected("vram_we");
        else begin
          e = exp_vram.pop_front();
          check("vram_waddr", 32'(vram_addr), 32'(e.a));
          check("vram_wdata", 32'(vram_wdata), 32'(e.d));
        end
      end
      if (oam_we) begin
        if (exp_oam.size() == 0) unexpected("oam_we");
        else begin
          e = exp_oam.pop_front();
          check("oam_waddr", 32'(oam_addr), 32'(e.a));
          check("oam_wdata", 32'(oam_wdata), 32'(e.d));
        end
      end
      if (dma_re) begin
        if (exp_dma.size() == 0) unexpected("dma_re");
        else begin
          da = exp_dma.pop_front();
          check("dma_addr", 32'(dma_addr), 32'(da));
        end
      end
      if (cpu_re && !cpu_stall) begin
        if (exp_rd.size() == 0) unexpected("cpu_read");
        else begin
          rr = exp_rd.pop_front();
          check("cpu_rdata", 32'(cpu_rdata), 32'(rr.d));
          check("status_rd", 32'(status_rd), 32'(rr.s));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic [7:0] d, input logic s);
    rd_t rr;
    rr.d = d; rr.s = s;
    exp_rd.push_back(rr);
    cpu_addr = a; cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0;
  endtask

  task automatic push_dma(input logic [7:0] page, input logic [7:0] base, input int n);
    wr_t e;
    logic [7:0] ib;
    for (int i = 0; i < n; i++) begin
      ib = 8'(i);
      exp_dma.push_back({page, ib});
      e.a = {8'h00, 8'(base + ib)};
      e.d = ib ^ 8'h5A;
      exp_oam.push_back(e);
    end
  endtask

  task automatic wait_dma(output int n);
    n = 0;
    while (cpu_stall && n < 2000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n;
  logic [7:0] pad0_bits [10];

  initial begin
    rst = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_we = 1'b0; cpu_re = 1'b0;
    ppu_status_in = 3'b101; pad_state = {8'h3C, 8'hA5};
    for (int i = 0; i < 16384; i++) vram_mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
    vram_mem[16'h2000] = 8'h11;
    vram_mem[16'h2001] = 8'h22;
    pad0_bits = '{8'h81, 8'h80, 8'h81, 8'h80, 8'h80, 8'h81, 8'h80, 8'h81, 8'h81, 8'h81};

    #3;
    check("rst_stall", 32'(cpu_stall), 32'h0);
    check("rst_vram_addr", 32'(vram_addr), 32'h0);
    check("rst_ppu_ctrl", 32'(ppu_ctrl), 32'h0);
    check("rst_oam_addr", 32'(oam_addr), 32'h0);
    check("rst_hit_0000", 32'(cpu_hit), 32'h0);
    #9 rst = 1'b1;
    tick();

    // Decode boundaries
    cpu_addr = 16'h1FFF; #1 check("hit_1FFF", 32'(cpu_hit), 32'h0);
    cpu_addr = 16'h3FFF; #1 check("hit_3FFF", 32'(cpu_hit), 32'h1);
    cpu_addr = 16'h4015; #1 check("hit_4015", 32'(cpu_hit), 32'h0);
    cpu_addr = 16'h4017; #1 check("hit_4017", 32'(cpu_hit), 32'h1);
    cpu_addr = 16'h4018; #1 check("hit_4018", 32'(cpu_hit), 32'h0);
    tick();

    // $2006 pair then $2007 writes with both increments
    cpu_write(16'h2006, 8'h21);
    cpu_write(16'h2006, 8'h08);
    check("vaddr_2108", 32'(vram_addr), 32'h2108);
    exp_vram.push_back({16'h2108, 8'hAB});
    cpu_write(16'h2007, 8'hAB);
    check("vaddr_2109", 32'(vram_addr), 32'h2109);
    cpu_write(16'h2000, 8'h04);
    check("ppu_ctrl_04", 32'(ppu_ctrl), 32'h04);
    exp_vram.push_back({16'h2109, 8'hCD});
    cpu_write(16'h2007, 8'hCD);
    check("vaddr_2129", 32'(vram_addr), 32'h2129);
    cpu_write(16'h3FF8, 8'h00);
    check("ppu_ctrl_mirror", 32'(ppu_ctrl), 32'h00);

    // Status read clears the write toggle
    cpu_write(16'h2006, 8'h3F);
    cpu_read(16'h2002, 8'hBF, 1'b1);
    cpu_write(16'h2006, 8'h20);
    cpu_write(16'h2006, 8'h00);
    check("vaddr_2000", 32'(vram_addr), 32'h2000);
    cpu_write(16'h2005, 8'h12);
    cpu_write(16'h2005, 8'h34);
    check("scroll_x", 32'(scroll_x), 32'h12);
    check("scroll_y", 32'(scroll_y), 32'h34);

    // Buffered $2007 reads and palette bypass
    cpu_read(16'h2007, 8'h00, 1'b0); tick();
    cpu_read(16'h2007, 8'h11, 1'b0); tick();
    cpu_write(16'h2006, 8'h3F);
    cpu_write(16'h2006, 8'h00);
    cpu_read(16'h2007, 8'hC0, 1'b0); tick();
    check("vaddr_3F01", 32'(vram_addr), 32'h3F01);

    // Open bus on write-only register, non-hit read
    cpu_write(16'h2001, 8'h1E);
    check("ppu_mask", 32'(ppu_mask), 32'h1E);
    cpu_read(16'h2001, 8'h1E, 1'b0);
    cpu_read(16'h4000, 8'h00, 1'b0);

    // OAM register port
    cpu_write(16'h2003, 8'h40);
    exp_oam.push_back({16'h0040, 8'h77});
    cpu_write(16'h2004, 8'h77);
    check("oam_addr_inc", 32'(oam_addr), 32'h41);
    cpu_write(16'h2003, 8'h40);
    cpu_read(16'h2004, 8'h77, 1'b0);

    // Full DMA with a write attempted while stalled
    cpu_write(16'h2003, 8'h10);
    push_dma(8'h02, 8'h10, OAM_DEPTH);
    cpu_write(16'h4014, 8'h02);
    n = 0;
    while (cpu_stall && n < 2000) begin
      if (n == 5) begin cpu_addr = 16'h2000; cpu_wdata = 8'hFF; cpu_we = 1'b1; end
      else cpu_we = 1'b0;
      tick();
      n++;
    end
    cpu_we = 1'b0;
    check("dma_stall_len", 32'(n), 32'd513);
    check("dma_oam_addr_kept", 32'(oam_addr), 32'h10);
    check("stall_gated_we", 32'(ppu_ctrl), 32'h00);
    cpu_read(16'h2000, 8'h02, 1'b0);
    check("dma_q_empty", 32'(exp_dma.size()), 32'd0);
    check("oam_q_empty", 32'(exp_oam.size()), 32'd0);

    // Reset during DMA at stall cycle 100 (RD of byte 49)
    push_dma(8'h03, 8'h10, 49);
    cpu_write(16'h4014, 8'h03);
    for (int c = 1; c < 100; c++) tick();
    rst = 1'b0;
    #1 check("abort_stall", 32'(cpu_stall), 32'h0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("abort_dma_q", 32'(exp_dma.size()), 32'd0);
    check("abort_oam_q", 32'(exp_oam.size()), 32'd0);
    check("abort_oam_addr", 32'(oam_addr), 32'h00);
    push_dma(8'h01, 8'h00, OAM_DEPTH);
    cpu_write(16'h4014, 8'h01);
    wait_dma(n);
    check("dma2_stall_len", 32'(n), 32'd513);
    check("dma2_q_empty", 32'(exp_dma.size() + exp_oam.size()), 32'd0);

    // Joypads
    cpu_write(16'h4016, 8'h01);
    cpu_read(16'h4016, 8'h01, 1'b0);
    cpu_write(16'h4016, 8'h80);
    for (int i = 0; i < 10; i++) cpu_read(16'h4016, pad0_bits[i], 1'b0);
    cpu_read(16'h4017, 8'h80, 1'b0);
    cpu_read(16'h4017, 8'h80, 1'b0);
    cpu_read(16'h4017, 8'h81, 1'b0);
    cpu_read(16'h4017, 8'h81, 1'b0);

    tick();
    check("end_rd_q", 32'(exp_rd.size()), 32'd0);
    check("end_vram_q", 32'(exp_vram.size()), 32'd0);
    check("end_oam_q", 32'(exp_oam.size()), 32'd0);
    check("end_dma_q", 32'(exp_dma.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
